mbist_mem_model: RTL and testbench



---
 rtl/mbist_mem_model_if.sv | 18 +
 rtl/mbist_mem_model.sv | 135 +++++++++++++
 tb/tb_mbist_mem_model.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_mem_model_if.sv
// Memory access bus between the MBIST controller (master) and the RAM model (slave).
//   read, write : access strobes from the controller
//   mem_addr    : word address
//   mem_din     : write data
//   mem_dout    : registered read data returned by the memory
interface mbist_mem_model_if #(
    parameter int unsigned addr = 4,
    parameter int unsigned data = 8
) ();
    logic            read;
    logic            write;
    logic [addr-1:0] mem_addr;
    logic [data-1:0] mem_din;
    logic [data-1:0] mem_dout;

    modport master (output read, write, mem_addr, mem_din, input mem_dout);
    modport slave  (input read, write, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/mbist_mem_model.sv
// Single-port synchronous RAM model with programmable fault slots (stuck-at-0,
// stuck-at-1, inversion coupling) used as the MBIST target memory.
//   clk, rst       : clock, asynchronous active-high reset
//   bus            : read/write/mem_addr/mem_din/mem_dout access port (slave side)
//   flt_load       : load slot flt_slot with flt_type/flt_addr/flt_bit/flt_aggr
//   flt_clear      : clear every slot to type none (wins over flt_load)
//   fault_active   : any slot currently holds a non-none type
//   wr_cnt         : writes performed since reset, saturating
module mbist_mem_model #(
    parameter int unsigned addr    = 4,
    parameter int unsigned data    = 8,
    parameter int unsigned NUM_FLT = 2,
    localparam int unsigned SLOT_W = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1,
    localparam int unsigned BIT_W  = (data > 1) ? $clog2(data) : 1
) (
    input  logic              clk,
    input  logic              rst,
    mbist_mem_model_if.slave  bus,
    input  logic              flt_load,
    input  logic [SLOT_W-1:0] flt_slot,
    input  logic [1:0]        flt_type,
    input  logic [addr-1:0]   flt_addr,
    input  logic [BIT_W-1:0]  flt_bit,
    input  logic [addr-1:0]   flt_aggr,
    input  logic              flt_clear,
    output logic              fault_active,
    output logic [15:0]       wr_cnt
);
    localparam int unsigned DEPTH = 1 << addr;
    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_SA0  = 2'd1;
    localparam logic [1:0] FLT_SA1  = 2'd2;
    localparam logic [1:0] FLT_CPL  = 2'd3;

    typedef logic [data-1:0] word_t;

    word_t            mem       [DEPTH];
    word_t            mem_next  [DEPTH];
    logic [1:0]       slot_type [NUM_FLT];
    logic [addr-1:0]  slot_addr [NUM_FLT];
    logic [BIT_W-1:0] slot_bit  [NUM_FLT];
    logic [addr-1:0]  slot_aggr [NUM_FLT];
    logic [1:0]       type_next [NUM_FLT];
    logic [addr-1:0]  addr_next [NUM_FLT];
    logic [BIT_W-1:0] bit_next  [NUM_FLT];
    logic [addr-1:0]  aggr_next [NUM_FLT];
    logic [DEPTH-1:0] touched;
    logic             load_ok;
    logic             any_next;
    word_t            rd_word;

    // Stuck-at forcing of word at address a; walking down to slot 0 lets slot 0 win.
    function automatic word_t force_word(input word_t w, input logic [addr-1:0] a);
        word_t r;
        r = w;
        for (int s = int'(NUM_FLT) - 1; s >= 0; s--) begin
            if (slot_addr[s] == a) begin
                if (slot_type[s] == FLT_SA0) r[slot_bit[s]] = 1'b0;
                else if (slot_type[s] == FLT_SA1) r[slot_bit[s]] = 1'b1;
            end
        end
        return r;
    endfunction

    // Next slot table; out-of-range slot or bit index drops the load.
    always_comb begin
        load_ok  = (32'(flt_slot) < NUM_FLT) && (32'(flt_bit) < data);
        any_next = 1'b0;
        for (int s = 0; s < int'(NUM_FLT); s++) begin
            type_next[s] = slot_type[s];
            addr_next[s] = slot_addr[s];
            bit_next[s]  = slot_bit[s];
            aggr_next[s] = slot_aggr[s];
            if (flt_clear) begin
                type_next[s] = FLT_NONE;
            end else if (flt_load && load_ok && (flt_slot == SLOT_W'(s))) begin
                type_next[s] = flt_type;
                addr_next[s] = flt_addr;
                bit_next[s]  = flt_bit;
                aggr_next[s] = flt_aggr;
            end
            if (type_next[s] != FLT_NONE) any_next = 1'b1;
        end
    end

    // Write path: normal write, then coupling inversions, then stuck-at on every word touched.
    always_comb begin
        touched = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem_next[i] = mem[i];
        mem_next[bus.mem_addr] = bus.mem_din;
        touched[bus.mem_addr]  = 1'b1;
        for (int s = 0; s < int'(NUM_FLT); s++) begin
            if ((slot_type[s] == FLT_CPL) && (slot_aggr[s] == bus.mem_addr) &&
                (slot_aggr[s] != slot_addr[s])) begin
                mem_next[slot_addr[s]][slot_bit[s]] = ~mem_next[slot_addr[s]][slot_bit[s]];
                touched[slot_addr[s]] = 1'b1;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (touched[i]) mem_next[i] = force_word(mem_next[i], addr'(i));
        end
    end

    always_comb rd_word = force_word(mem[bus.mem_addr], bus.mem_addr);

    // Storage, fault table and status registers; write wins over read with dout holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            for (int s = 0; s < int'(NUM_FLT); s++) begin
                slot_type[s] <= FLT_NONE;
                slot_addr[s] <= '0;
                slot_bit[s]  <= '0;
                slot_aggr[s] <= '0;
            end
            bus.mem_dout <= '0;
            fault_active <= 1'b0;
            wr_cnt       <= '0;
        end else begin
            for (int s = 0; s < int'(NUM_FLT); s++) begin
                slot_type[s] <= type_next[s];
                slot_addr[s] <= addr_next[s];
                slot_bit[s]  <= bit_next[s];
                slot_aggr[s] <= aggr_next[s];
            end
            fault_active <= any_next;
            if (bus.write) begin
                for (int i = 0; i < int'(DEPTH); i++) mem[i] <= mem_next[i];
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else if (bus.read) begin
                bus.mem_dout <= rd_word;
            end
        end
    end
endmodule

// File: tb/tb_mbist_mem_model.sv
// Self-checking bench for mbist_mem_model: directed scenarios, bench-side march
// runs and randomized traffic, scored against a behavioural memory model.
module tb_mbist_mem_model;
    logic        clk;
    logic        rst;
    logic        flt_load;
    logic [0:0]  flt_slot;
    logic [1:0]  flt_type;
    logic [3:0]  flt_addr;
    logic [2:0]  flt_bit;
    logic [3:0]  flt_aggr;
    logic        flt_clear;
    logic        fault_active;
    logic [15:0] wr_cnt;

    mbist_mem_model_if #(.addr(4), .data(8)) bus ();

    mbist_mem_model #(.addr(4), .data(8), .NUM_FLT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flt_load     (flt_load),
        .flt_slot     (flt_slot),
        .flt_type     (flt_type),
        .flt_addr     (flt_addr),
        .flt_bit      (flt_bit),
        .flt_aggr     (flt_aggr),
        .flt_clear    (flt_clear),
        .fault_active (fault_active),
        .wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    int         m_type [2];
    int         m_addr [2];
    int         m_bit  [2];
    int         m_aggr [2];
    int         m_wr;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_forced(input logic [7:0] w, input int a);
        logic [7:0] r;
        r = w;
        for (int s = 1; s >= 0; s--) begin
            if (m_addr[s] == a && m_type[s] == 1) r[m_bit[s]] = 1'b0;
            if (m_addr[s] == a && m_type[s] == 2) r[m_bit[s]] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic m_active();
        return (m_type[0] != 0) || (m_type[1] != 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        for (int s = 0; s < 2; s++) begin
            m_type[s] = 0; m_addr[s] = 0; m_bit[s] = 0; m_aggr[s] = 0;
        end
        m_wr = 0;
    endtask

    // One clock edge of the reference: access under the old fault table, then config update.
    task automatic m_edge(input bit rd, input bit wr, input int a, input int din);
        bit hit [16];
        int v;
        for (int i = 0; i < 16; i++) hit[i] = 1'b0;
        if (rd && !wr) exp_q.push_back(m_forced(m_mem[a], a));
        if (wr) begin
            m_mem[a] = 8'(din);
            hit[a] = 1'b1;
            for (int s = 0; s < 2; s++) begin
                if (m_type[s] == 3 && m_aggr[s] == a && m_aggr[s] != m_addr[s]) begin
                    v = m_addr[s];
                    m_mem[v][m_bit[s]] = ~m_mem[v][m_bit[s]];
                    hit[v] = 1'b1;
                end
            end
            for (int i = 0; i < 16; i++) if (hit[i]) m_mem[i] = m_forced(m_mem[i], i);
            if (m_wr < 65535) m_wr++;
        end
        if (flt_clear) begin
            m_type[0] = 0; m_type[1] = 0;
        end else if (flt_load) begin
            v = int'(flt_slot);
            m_type[v] = int'(flt_type);
            m_addr[v] = int'(flt_addr);
            m_bit[v]  = int'(flt_bit);
            m_aggr[v] = int'(flt_aggr);
        end
    endtask

    task automatic step(input bit rd, input bit wr, input int a, input int din);
        bus.read     = rd;
        bus.write    = wr;
        bus.mem_addr = 4'(a);
        bus.mem_din  = 8'(din);
        @(posedge clk);
        m_edge(rd, wr, a, din);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        flt_load  = 1'b0;
        flt_clear = 1'b0;
        chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        chk("fault_active", 32'(fault_active), 32'(m_active()));
    endtask

    task automatic load(input int s, input int t, input int a, input int b, input int g);
        flt_load = 1'b1;
        flt_slot = 1'(s);
        flt_type = 2'(t);
        flt_addr = 4'(a);
        flt_bit  = 3'(b);
        flt_aggr = 4'(g);
        step(0, 0, 0, 0);
    endtask

    task automatic clear_all();
        flt_clear = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic rd_chk(input string name, input int a, input logic [7:0] exp);
        step(1, 0, a, 0);
        chk(name, 32'(bus.mem_dout), 32'(exp));
    endtask

    // Bench-side march: write/read a solid pattern both ways, record first failing address.
    task automatic march(output bit fail, output int fail_addr);
        logic [7:0] pat;
        fail = 1'b0;
        fail_addr = -1;
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 8'h00 : 8'hFF;
            for (int a = 0; a < 16; a++) step(0, 1, a, int'(pat));
            for (int a = 0; a < 16; a++) begin
                step(1, 0, a, 0);
                if (bus.mem_dout !== pat && !fail) begin
                    fail = 1'b1;
                    fail_addr = a;
                end
            end
        end
    endtask

    // Monitor: read data is valid by the falling edge after the sampling edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(bus.mem_dout), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fail;
        int fa;
        int r;
        rst = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.mem_addr = '0; bus.mem_din = '0;
        flt_load = 1'b0; flt_slot = '0; flt_type = '0; flt_addr = '0;
        flt_bit = '0; flt_aggr = '0; flt_clear = 1'b0;
        m_reset();
        #1;
        chk("rst_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
        chk("rst_fault_active", 32'(fault_active), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Plain write/read
        step(0, 1, 3, 8'h55);
        rd_chk("basic_rd", 3, 8'h55);
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd1);

        // Stuck-at-0
        load(0, 1, 5, 2, 0);
        chk("sa0_active", 32'(fault_active), 32'd1);
        step(0, 1, 5, 8'hFF);
        step(0, 1, 6, 8'hFF);
        rd_chk("sa0_victim", 5, 8'hFB);
        rd_chk("sa0_neighbour", 6, 8'hFF);

        // Slot priority on conflicting stuck-ats, then removing slot 0
        load(1, 2, 0, 7, 0);
        load(0, 1, 0, 7, 0);
        step(0, 1, 0, 8'h00);
        rd_chk("prio_slot0", 0, 8'h00);
        load(0, 0, 0, 0, 0);
        rd_chk("prio_slot1", 0, 8'h80);

        // Coupling invert
        clear_all();
        chk("clear_inactive", 32'(fault_active), 32'd0);
        load(0, 3, 9, 0, 2);
        step(0, 1, 9, 8'h00);
        step(0, 1, 2, 8'hAA);
        rd_chk("cpl_once", 9, 8'h01);
        step(0, 1, 2, 8'hAA);
        rd_chk("cpl_twice", 9, 8'h00);
        rd_chk("cpl_aggr", 2, 8'hAA);

        // Simultaneous read and write: write wins, dout holds
        clear_all();
        step(0, 1, 4, 8'h55);
        rd_chk("rw_pre", 4, 8'h55);
        step(1, 1, 4, 8'h3C);
        chk("rw_hold", 32'(bus.mem_dout), 32'h55);
        rd_chk("rw_after", 4, 8'h3C);

        // March passes, fault-free then with SA1 @7 bit 0
        march(fail, fa);
        chk("march_clean_fail", 32'(fail), 32'd0);
        load(1, 2, 7, 0, 0);
        march(fail, fa);
        chk("march_sa1_fail", 32'(fail), 32'd1);
        chk("march_sa1_addr", 32'(fa), 32'd7);

        // Reset in the middle of activity
        step(0, 1, 3, 8'hA5);
        rd_chk("pre_rst", 3, 8'hA5);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        chk("midrst_dout", 32'(bus.mem_dout), 32'h0);
        chk("midrst_wr_cnt", 32'(wr_cnt), 32'h0);
        chk("midrst_active", 32'(fault_active), 32'h0);
        #2;
        rst = 1'b0;
        for (int a = 0; a < 16; a++) rd_chk("post_rst_zero", a, 8'h00);

        // Randomized traffic with occasional fault loads and clears
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                flt_load = 1'b1;
                flt_slot = 1'($urandom_range(0, 1));
                flt_type = 2'($urandom_range(0, 3));
                flt_addr = 4'($urandom_range(0, 15));
                flt_bit  = 3'($urandom_range(0, 7));
                flt_aggr = 4'($urandom_range(0, 15));
            end
            if (r >= 8 && r < 11) flt_clear = 1'b1;
            step(bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
